// File: rtl/jogador_automatico.sv
// -----------------------------------------------------------------------------
// jogador_automatico
//
// Hardware auto-player for the memory game. It watches the game's `leds`
// output while a sequence is being shown and stores every new symbol. When the
// game hands the turn to the player (rising edge of `vez_jogador`), it replays
// the stored symbols on `botoes`. Each press is held for PRESS_CYCLES cycles
// and followed by GAP_CYCLES cycles of zero.
//
// Optional build macro: JOGADOR_ERRO_INJETADO_EN
//   When defined, the ports `erro_pos` and `erro_ativo` are added. While
//   erro_ativo=1, the press at index erro_pos is rotated left by one bit, so
//   that the player makes a deliberate mistake.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   habilitar    in   enables the bot; 0 forces OCIOSO
//   leds[3:0]    in   game LED output (one-hot symbol or 0)
//   vez_jogador  in   game is waiting for player input
//   ganhou       in   game won
//   perdeu       in   game lost
//   botoes[3:0]  out  registered button drive to the game
//   ocupado      out  high while replaying (PRESSIONA/SOLTA)
//   overflow     out  sticky; a symbol was dropped because the buffer was full
//   db_contagem  out  number of stored symbols
//   db_estado    out  state code (OCIOSO=0 OBSERVA=1 PRESSIONA=2 SOLTA=3 FIM=4)
//
// Handshake: there is no valid/ready pair. A capture is triggered by a 0->nonzero
// transition of `leds` while vez_jogador=0. A replay is triggered by a 0->1
// transition of vez_jogador. Both inputs are compared against copies that are
// registered every cycle.
// -----------------------------------------------------------------------------
module jogador_automatico #(
  parameter int PRESS_CYCLES = 3,
  parameter int GAP_CYCLES   = 3,
  parameter int ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              habilitar,
  input  logic [3:0]        leds,
  input  logic              vez_jogador,
  input  logic              ganhou,
  input  logic              perdeu,
`ifdef JOGADOR_ERRO_INJETADO_EN
  input  logic [ADDR_W-1:0] erro_pos,
  input  logic              erro_ativo,
`endif
  output logic [3:0]        botoes,
  output logic              ocupado,
  output logic              overflow,
  output logic [ADDR_W:0]   db_contagem,
  output logic [2:0]        db_estado
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TMAX  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    OBSERVA   = 3'd1,
    PRESSIONA = 3'd2,
    SOLTA     = 3'd3,
    FIM       = 3'd4
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [3:0]        botoes_q, botoes_d;
  logic              ocupado_q, ocupado_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        leds_r_q;
  logic              vez_r_q;

  logic [3:0]        mem_q [DEPTH];
  logic              wr_en;

  logic              vez_edge;
  logic              capture;
  logic [ADDR_W-1:0] idx_nxt;
  logic [ADDR_W:0]   idx_plus;
  logic [3:0]        sym_first;
  logic [3:0]        sym_next;

  assign vez_edge = vez_jogador & ~vez_r_q;
  assign capture  = (leds != 4'd0) & (leds_r_q == 4'd0) & ~vez_jogador;
  assign idx_nxt  = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign idx_plus = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};

  // Symbols that may be loaded into botoes: index 0 when a replay starts,
  // and idx+1 when one press follows another.
`ifdef JOGADOR_ERRO_INJETADO_EN
  assign sym_first = (erro_ativo && (erro_pos == {ADDR_W{1'b0}}))
                     ? {mem_q[0][2:0], mem_q[0][3]} : mem_q[0];
  assign sym_next  = (erro_ativo && (erro_pos == idx_nxt))
                     ? {mem_q[idx_nxt][2:0], mem_q[idx_nxt][3]} : mem_q[idx_nxt];
`else
  assign sym_first = mem_q[0];
  assign sym_next  = mem_q[idx_nxt];
`endif

  always_comb begin
    estado_d   = estado_q;
    botoes_d   = botoes_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    wr_en      = 1'b0;

    if (!habilitar) begin
      estado_d = OCIOSO;
      botoes_d = 4'd0;
    end else if ((estado_q != OCIOSO) && (ganhou || perdeu)) begin
      estado_d = FIM;
      botoes_d = 4'd0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          botoes_d   = 4'd0;
          estado_d   = OBSERVA;
          count_d    = '0;
          overflow_d = 1'b0;
        end
        OBSERVA: begin
          botoes_d = 4'd0;
          // The replay edge has priority over a capture in the same cycle.
          if (vez_edge) begin
            if (count_q != '0) begin
              estado_d = PRESSIONA;
              idx_d    = '0;
              timer_d  = '0;
              botoes_d = sym_first;
            end
          end else if (capture) begin
            if (count_q < (ADDR_W+1)'(DEPTH)) begin
              wr_en   = 1'b1;
              count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        PRESSIONA: begin
          if (timer_q == TW'(PRESS_CYCLES - 1)) begin
            estado_d = SOLTA;
            timer_d  = '0;
            botoes_d = 4'd0;
          end else begin
            timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        SOLTA: begin
          botoes_d = 4'd0;
          if (timer_q == TW'(GAP_CYCLES - 1)) begin
            timer_d = '0;
            if (idx_plus < count_q) begin
              idx_d    = idx_nxt;
              estado_d = PRESSIONA;
              botoes_d = sym_next;
            end else begin
              count_d  = '0;
              estado_d = OBSERVA;
            end
          end else begin
            timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        FIM: begin
          botoes_d = 4'd0;
        end
        default: begin
          estado_d = OCIOSO;
          botoes_d = 4'd0;
        end
      endcase
    end

    ocupado_d = (estado_d == PRESSIONA) || (estado_d == SOLTA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      botoes_q   <= 4'd0;
      ocupado_q  <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      leds_r_q   <= 4'd0;
      vez_r_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      botoes_q   <= botoes_d;
      ocupado_q  <= ocupado_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      leds_r_q   <= leds;
      vez_r_q    <= vez_jogador;
    end
  end

  // The symbol buffer has no reset; its contents are only read below count_q.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[count_q[ADDR_W-1:0]] <= leds;
    end
  end

  assign botoes      = botoes_q;
  assign ocupado     = ocupado_q;
  assign overflow    = overflow_q;
  assign db_contagem = count_q;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
module tb_jogador_automatico;

  localparam int P = 3;
  localparam int G = 3;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          habilitar;
  logic [3:0]    leds;
  logic          vez_jogador;
  logic          ganhou;
  logic          perdeu;
  logic [3:0]    botoes;
  logic          ocupado;
  logic          overflow;
  logic [AW:0]   db_contagem;
  logic [2:0]    db_estado;
`ifdef JOGADOR_ERRO_INJETADO_EN
  logic [AW-1:0] erro_pos;
  logic          erro_ativo;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the symbols the game has shown since the last replay,
  // plus the sticky overflow flag.
  logic [3:0] stored_q[$];
  logic       model_ovf;
  logic [3:0] exp_q[$];

  jogador_automatico #(.PRESS_CYCLES(P), .GAP_CYCLES(G), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .habilitar   (habilitar),
    .leds        (leds),
    .vez_jogador (vez_jogador),
    .ganhou      (ganhou),
    .perdeu      (perdeu),
`ifdef JOGADOR_ERRO_INJETADO_EN
    .erro_pos    (erro_pos),
    .erro_ativo  (erro_ativo),
`endif
    .botoes      (botoes),
    .ocupado     (ocupado),
    .overflow    (overflow),
    .db_contagem (db_contagem),
    .db_estado   (db_estado)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: show one symbol on leds for `hold` cycles, then 0 for `gap` cycles.
  task automatic pulse(input logic [3:0] sym, input int hold, input int gap);
    leds = sym;
    repeat (hold) tick();
    leds = 4'd0;
    repeat (gap) tick();
    if (stored_q.size() < 16) stored_q.push_back(sym);
    else model_ovf = 1'b1;
  endtask

  // Driver + scoreboard: raise vez_jogador and check every replay cycle.
  task automatic replay(input string tag);
    logic [3:0] s;
    exp_q.delete();
    for (int i = 0; i < stored_q.size(); i++) begin
      s = stored_q[i];
`ifdef JOGADOR_ERRO_INJETADO_EN
      if (erro_ativo && (i == int'(erro_pos))) s = 4'(((s << 1) | (s >> 3)) & 4'hf);
`endif
      repeat (P) exp_q.push_back(s);
      repeat (G) exp_q.push_back(4'd0);
    end
    chk({tag, "_count"}, 32'(db_contagem), stored_q.size());
    vez_jogador = 1'b1;
    while (exp_q.size() > 0) begin
      tick();
      s = exp_q.pop_front();
      chk({tag, "_botoes"}, 32'(botoes), 32'(s));
      chk({tag, "_ocupado"}, 32'(ocupado), 32'd1);
    end
    tick();
    chk({tag, "_end_count"}, 32'(db_contagem), 32'd0);
    chk({tag, "_end_state"}, 32'(db_estado), 32'd1);
    chk({tag, "_end_botoes"}, 32'(botoes), 32'd0);
    chk({tag, "_end_ovf"}, 32'(overflow), 32'(model_ovf));
    vez_jogador = 1'b0;
    stored_q.delete();
    tick();
  endtask

  task automatic reenable();
    habilitar = 1'b0;
    tick();
    habilitar = 1'b1;
    tick();
    stored_q.delete();
    model_ovf = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; habilitar = 1'b0; leds = 4'd0; vez_jogador = 1'b0;
    ganhou = 1'b0; perdeu = 1'b0; model_ovf = 1'b0;
`ifdef JOGADOR_ERRO_INJETADO_EN
    erro_pos = '0; erro_ativo = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_botoes", 32'(botoes), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_count", 32'(db_contagem), 32'd0);
    chk("rst_state", 32'(db_estado), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_state", 32'(db_estado), 32'd0);
    habilitar = 1'b1;
    tick();
    chk("enable_state", 32'(db_estado), 32'd1);

    // Directed: two symbols, long pulses.
    pulse(4'b0001, 20, 10);
    pulse(4'b0100, 20, 10);
    replay("dir2");

    // Random rounds; symbols stored as-is (not necessarily one-hot).
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        pulse(4'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(1, 3));
      replay("rand");
    end

    // Overflow: 17 captures, 16 kept; flag is sticky through the replay.
    for (int i = 0; i < 17; i++) pulse(4'(1 << (i % 4)), 1, 1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    replay("ovf");
    reenable();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Reset during the 2nd cycle of a press of 0010.
    pulse(4'b0010, 3, 2);
    vez_jogador = 1'b1;
    tick();
    chk("rstmid_p1", 32'(botoes), 32'h2);
    tick();
    chk("rstmid_p2", 32'(botoes), 32'h2);
    reset = 1'b1;
    tick();
    chk("rstmid_botoes", 32'(botoes), 32'd0);
    chk("rstmid_state", 32'(db_estado), 32'd0);
    chk("rstmid_count", 32'(db_contagem), 32'd0);
    reset = 1'b0; vez_jogador = 1'b0;
    tick();
    chk("rstmid_resume", 32'(db_estado), 32'd1);
    stored_q.delete();

    // vez_jogador edge with nothing stored.
    vez_jogador = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("empty_botoes", 32'(botoes), 32'd0);
      chk("empty_state", 32'(db_estado), 32'd1);
    end
    vez_jogador = 1'b0;
    tick();

    // Capture and replay edge in the same cycle: replay wins, symbol dropped.
    pulse(4'b1000, 2, 2);
    leds = 4'b0100;
    replay("simul");
    leds = 4'b0000;
    tick();
    chk("simul_nocap", 32'(db_contagem), 32'd0);

    // perdeu during SOLTA -> FIM; held until habilitar=0.
    pulse(4'b0001, 2, 1);
    pulse(4'b0010, 2, 1);
    vez_jogador = 1'b1;
    repeat (P) tick();
    chk("lose_pressed", 32'(botoes), 32'h1);
    tick();
    chk("lose_solta", 32'(db_estado), 32'd3);
    perdeu = 1'b1;
    tick();
    chk("lose_fim", 32'(db_estado), 32'd4);
    chk("lose_botoes", 32'(botoes), 32'd0);
    chk("lose_ocupado", 32'(ocupado), 32'd0);
    perdeu = 1'b0; vez_jogador = 1'b0;
    repeat (3) tick();
    chk("fim_hold", 32'(db_estado), 32'd4);
    habilitar = 1'b0;
    tick();
    chk("fim_exit", 32'(db_estado), 32'd0);
    habilitar = 1'b1;
    tick();
    stored_q.delete();

    // habilitar=0 mid-press forces OCIOSO and releases the button.
    pulse(4'b0100, 2, 1);
    vez_jogador = 1'b1;
    tick();
    chk("dis_press", 32'(botoes), 32'h4);
    habilitar = 1'b0;
    tick();
    chk("dis_botoes", 32'(botoes), 32'd0);
    chk("dis_state", 32'(db_estado), 32'd0);
    vez_jogador = 1'b0;
    habilitar = 1'b1;
    tick();
    stored_q.delete();
    model_ovf = 1'b0;

`ifdef JOGADOR_ERRO_INJETADO_EN
    erro_ativo = 1'b1; erro_pos = 4'd1;
    pulse(4'b0001, 2, 1);
    pulse(4'b1000, 2, 1);
    replay("erro");
    erro_ativo = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
